// File: rtl/isp_pkg.sv
// Shared types for the intersection phase scheduler.
//   phase_e : scheduler state encoding, also exported on the phase port
//   dir_e   : road that receives the next green after an all-red
//   max_of5 : largest of five durations, used to size the phase timer
package isp_pkg;

    typedef enum logic [3:0] {
        ALL_RED   = 4'd0,
        NS_GREEN  = 4'd1,
        NS_YELLOW = 4'd2,
        EW_GREEN  = 4'd3,
        EW_YELLOW = 4'd4,
        PED_WALK  = 4'd5,
        EMERG     = 4'd6
    } phase_e;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } dir_e;

    function automatic int max_of5(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: loadable down-counter with an expire flag, plus an up-counter
// of cycles spent in the current phase.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : restart both counters for a new phase
//   load_value   : duration of the new phase in cycles
//   expired      : high during the last cycle of a timed phase
//   elapsed      : 1 in the first cycle of a phase, saturates at all-ones
module phase_timer #(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired,
    output logic [WIDTH-1:0] elapsed
);

    logic [WIDTH-1:0] remaining;

    // A phase of N cycles starts at N and expires when one cycle is left,
    // so the transition lands exactly after N cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= RESET_VALUE;
            elapsed   <= WIDTH'(1);
        end else if (load) begin
            remaining <= load_value;
            elapsed   <= WIDTH'(1);
        end else begin
            if (remaining != '0) remaining <= remaining - 1'b1;
            if (elapsed != '1)   elapsed   <= elapsed + 1'b1;
        end
    end

    assign expired = (remaining <= WIDTH'(1));

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Intersection phase scheduler: Moore FSM sequencing NS (main) and EW (side)
// greens, a shared pedestrian walk phase and emergency pre-emption.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   ns_car, ew_car                  : vehicle presence, level
//   ped_request                     : pedestrian button, latched into ped_pending
//   emergency                       : pre-emption request, level
//   ns_red/ns_yellow/ns_green       : NS lamps
//   ew_red/ew_yellow/ew_green       : EW lamps
//   ped_walk, ped_dont_walk         : pedestrian signals
//   phase                           : current state encoding
//   ped_pending                     : latched pedestrian request
module intersection_phase_scheduler
    import isp_pkg::*;
#(
    parameter int GREEN_MIN    = 8,
    parameter int GREEN_MAX    = 20,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_request,
    input  logic       emergency,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic       ped_dont_walk,
    output logic [3:0] phase,
    output logic       ped_pending
);

    localparam int TW = $clog2(max_of5(GREEN_MIN, GREEN_MAX, YELLOW_TIME,
                                       ALL_RED_TIME, WALK_TIME) + 1);

    localparam logic [TW-1:0] T_GREEN_MIN = TW'(GREEN_MIN);
    localparam logic [TW-1:0] T_GREEN_MAX = TW'(GREEN_MAX);
    localparam logic [TW-1:0] T_YELLOW    = TW'(YELLOW_TIME);
    localparam logic [TW-1:0] T_ALL_RED   = TW'(ALL_RED_TIME);
    localparam logic [TW-1:0] T_WALK      = TW'(WALK_TIME);

    phase_e          state, state_next;
    dir_e            next_dir;
    logic            to_ew, to_ns;
    logic            timer_load;
    logic [TW-1:0]   timer_value;
    logic            timer_expired;
    logic [TW-1:0]   elapsed;

    // NS is the rest road and holds green without a call, so its presence
    // sensor never changes the sequence.
    logic unused_ns_car;
    assign unused_ns_car = ns_car;

    phase_timer #(
        .WIDTH       (TW),
        .RESET_VALUE (T_ALL_RED)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired),
        .elapsed    (elapsed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALL_RED;
        end else begin
            state <= state_next;
        end
    end

    // Emergency overrides demand and timers, but a yellow always runs to
    // completion. A green cut short by emergency does not hand the next
    // green to the other road, so the interrupted road is served again.
    always_comb begin
        state_next = state;
        to_ew      = 1'b0;
        to_ns      = 1'b0;
        unique case (state)
            ALL_RED: begin
                if (emergency)          state_next = EMERG;
                else if (timer_expired) begin
                    if (ped_pending)         state_next = PED_WALK;
                    else if (next_dir == NS) state_next = NS_GREEN;
                    else                     state_next = EW_GREEN;
                end
            end
            NS_GREEN: begin
                if (emergency) begin
                    state_next = NS_YELLOW;
                end else if ((ew_car || ped_pending) &&
                             (elapsed >= T_GREEN_MIN || elapsed >= T_GREEN_MAX)) begin
                    state_next = NS_YELLOW;
                    to_ew      = 1'b1;
                end
            end
            EW_GREEN: begin
                if (emergency) begin
                    state_next = EW_YELLOW;
                end else if (elapsed >= T_GREEN_MAX ||
                             (elapsed >= T_GREEN_MIN && !ew_car)) begin
                    state_next = EW_YELLOW;
                    to_ns      = 1'b1;
                end
            end
            NS_YELLOW, EW_YELLOW: begin
                if (timer_expired) state_next = emergency ? EMERG : ALL_RED;
            end
            PED_WALK: begin
                if (emergency)          state_next = EMERG;
                else if (timer_expired) state_next = ALL_RED;
            end
            EMERG: begin
                if (!emergency) state_next = ALL_RED;
            end
            default: state_next = ALL_RED;
        endcase
    end

    // The timer restarts on every state change with the new state's duration;
    // greens and EMERG time themselves from elapsed or the emergency level.
    always_comb begin
        timer_load  = (state_next != state);
        timer_value = '0;
        unique case (state_next)
            ALL_RED:              timer_value = T_ALL_RED;
            NS_YELLOW, EW_YELLOW: timer_value = T_YELLOW;
            PED_WALK:             timer_value = T_WALK;
            default:              timer_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_dir <= NS;
        end else if (to_ew) begin
            next_dir <= EW;
        end else if (to_ns) begin
            next_dir <= NS;
        end
    end

    // Entering the walk serves the request, which takes precedence over a
    // button press sampled on that same edge; presses during the walk are
    // dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
        end else if (state_next == PED_WALK && state != PED_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_request && state != PED_WALK) begin
            ped_pending <= 1'b1;
        end
    end

    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        ped_walk  = 1'b0;
        unique case (state)
            NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
            NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
            EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
            EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
            PED_WALK:  ped_walk = 1'b1;
            default:   ;
        endcase
        ped_dont_walk = ~ped_walk;
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with default parameters.
module tb_intersection_phase_scheduler;
    import isp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_request = 1'b0;
    logic       emergency = 1'b0;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ped_walk, ped_dont_walk;
    logic [3:0] phase;
    logic       ped_pending;

    int total = 0;
    int bad   = 0;

    intersection_phase_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ns_car        (ns_car),
        .ew_car        (ew_car),
        .ped_request   (ped_request),
        .emergency     (emergency),
        .ns_red        (ns_red),
        .ns_yellow     (ns_yellow),
        .ns_green      (ns_green),
        .ew_red        (ew_red),
        .ew_yellow     (ew_yellow),
        .ew_green      (ew_green),
        .ped_walk      (ped_walk),
        .ped_dont_walk (ped_dont_walk),
        .phase         (phase),
        .ped_pending   (ped_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Lamp vector {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk,dont_walk} per phase.
    function automatic logic [7:0] lamps_for(input phase_e p);
        case (p)
            NS_GREEN:  return 8'b001_100_01;
            NS_YELLOW: return 8'b010_100_01;
            EW_GREEN:  return 8'b100_001_01;
            EW_YELLOW: return 8'b100_010_01;
            PED_WALK:  return 8'b100_100_10;
            default:   return 8'b100_100_01;
        endcase
    endfunction

    task automatic applyStimulus(input logic ns, input logic ew,
                                 input logic ped, input logic emg);
        ns_car      = ns;
        ew_car      = ew;
        ped_request = ped;
        emergency   = emg;
    endtask

    task automatic checkOutput(input string tag, input phase_e exp_phase);
        logic [7:0] obs_lamps;
        logic [7:0] exp_lamps;
        obs_lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                     ped_walk, ped_dont_walk};
        exp_lamps = lamps_for(exp_phase);
        total++;
        assert (phase === exp_phase) else begin
            bad++;
            $error("[TB] FAIL %s phase: observed=%0d expected=%0d", tag, phase, exp_phase);
        end
        total++;
        assert (obs_lamps === exp_lamps) else begin
            bad++;
            $error("[TB] FAIL %s lamps: observed=%b expected=%b", tag, obs_lamps, exp_lamps);
        end
    endtask

    task automatic checkPending(input string tag, input logic exp);
        total++;
        assert (ped_pending === exp) else begin
            bad++;
            $error("[TB] FAIL %s ped_pending: observed=%b expected=%b", tag, ped_pending, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the phase for n consecutive cycles, leaving the bench at the
    // first cycle after the run.
    task automatic expectRun(input string tag, input phase_e p, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(tag, p);
            step();
        end
    endtask

    // Called #1 after an edge; checks the reset decode before any clock
    // edge and releases so the bench sits in the first ALL_RED cycle.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #2;
        checkOutput(tag, ALL_RED);
        checkPending(tag, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        step();

        // 1: idle power-up rests in NS green; late EW call ends it at once
        doReset("s1_reset");
        expectRun("s1_allred", ALL_RED, 2);
        expectRun("s1_nsg_hold", NS_GREEN, 52);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s1_nsg_last", NS_GREEN);
        step();
        checkOutput("s1_nsy_after_hold", NS_YELLOW);

        // 2: continuous EW demand from NS green cycle 3, EW runs to max
        doReset("s2_reset");
        expectRun("s2_allred", ALL_RED, 2);
        expectRun("s2_nsg_pre", NS_GREEN, 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        expectRun("s2_nsg", NS_GREEN, 6);
        expectRun("s2_nsy", NS_YELLOW, 3);
        expectRun("s2_allred2", ALL_RED, 2);
        expectRun("s2_ewg_max", EW_GREEN, 20);
        expectRun("s2_ewy", EW_YELLOW, 3);
        expectRun("s2_allred3", ALL_RED, 2);
        checkOutput("s2_back_ns", NS_GREEN);

        // 3: pedestrian pulse in NS green cycle 2, then EW minimum green
        doReset("s3_reset");
        expectRun("s3_allred", ALL_RED, 2);
        expectRun("s3_nsg_c1", NS_GREEN, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkPending("s3_pend_before", 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkPending("s3_pend_latched", 1'b1);
        expectRun("s3_nsg", NS_GREEN, 6);
        expectRun("s3_nsy", NS_YELLOW, 3);
        expectRun("s3_allred2", ALL_RED, 1);
        checkPending("s3_pend_held", 1'b1);
        expectRun("s3_allred2b", ALL_RED, 1);
        checkPending("s3_pend_cleared", 1'b0);
        expectRun("s3_walk_c1", PED_WALK, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expectRun("s3_walk_c2", PED_WALK, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkPending("s3_walk_ignores_req", 1'b0);
        expectRun("s3_walk_rest", PED_WALK, 4);
        expectRun("s3_allred3", ALL_RED, 2);
        expectRun("s3_ewg_min", EW_GREEN, 8);
        expectRun("s3_ewy", EW_YELLOW, 3);
        expectRun("s3_allred4", ALL_RED, 2);
        checkOutput("s3_back_ns", NS_GREEN);

        // 4: emergency in NS green cycle 2, held for 15 EMERG cycles
        doReset("s4_reset");
        expectRun("s4_allred", ALL_RED, 2);
        expectRun("s4_nsg_c1", NS_GREEN, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectRun("s4_nsg_c2", NS_GREEN, 1);
        expectRun("s4_nsy", NS_YELLOW, 3);
        expectRun("s4_emerg", EMERG, 14);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectRun("s4_emerg_last", EMERG, 1);
        expectRun("s4_allred", ALL_RED, 2);
        checkOutput("s4_ns_again", NS_GREEN);

        // 5: emergency truncates walk; request during EMERG is kept
        doReset("s5_reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        expectRun("s5_allred_c1", ALL_RED, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkPending("s5_pend", 1'b1);
        expectRun("s5_allred_c2", ALL_RED, 1);
        expectRun("s5_walk", PED_WALK, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        expectRun("s5_walk_c3", PED_WALK, 1);
        expectRun("s5_emerg", EMERG, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        expectRun("s5_emerg_req", EMERG, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkPending("s5_pend_in_emerg", 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        expectRun("s5_emerg_last", EMERG, 1);
        expectRun("s5_allred", ALL_RED, 2);
        checkPending("s5_pend_served", 1'b0);
        expectRun("s5_walk2", PED_WALK, 6);
        expectRun("s5_allred2", ALL_RED, 2);
        checkOutput("s5_ns", NS_GREEN);

        // 6: asynchronous reset mid EW yellow with a pending request
        doReset("s6_reset_pre");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        expectRun("s6_allred", ALL_RED, 2);
        expectRun("s6_nsg", NS_GREEN, 8);
        expectRun("s6_nsy", NS_YELLOW, 3);
        expectRun("s6_allred2", ALL_RED, 2);
        expectRun("s6_ewg_c1", EW_GREEN, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        expectRun("s6_ewg_c2", EW_GREEN, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        expectRun("s6_ewg", EW_GREEN, 18);
        expectRun("s6_ewy", EW_YELLOW, 1);
        checkPending("s6_pend_before_reset", 1'b1);
        doReset("s6_async_reset");
        expectRun("s6_allred_again", ALL_RED, 2);
        expectRun("s6_nsg_again", NS_GREEN, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
